component_bit_packer: RTL and testbench

//  Packs variable-length DC/AC VLC codewords into 32-bit big-endian stream words.

---
 rtl/component_bit_packer.sv | 145 ++++++++++++++
 tb/tb_component_bit_packer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/component_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into 32-bit big-endian
// words, with zero-padded flush and running bit/word counts for slice accounting.
module component_bit_packer #(
    parameter int WORD_WIDTH   = 32,
    parameter int MAX_CODE_LEN = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_enable,
    input  logic [31:0]           in_code,
    input  logic [5:0]            in_length,
    input  logic                  flush,
    output logic                  busy,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic                  flush_done,
    output logic [31:0]           bit_count,
    output logic [15:0]           word_count,
    output logic                  error
);

    typedef enum logic {
        RUN,
        FLUSH2
    } state_t;

    state_t                  state_q, state_d;
    logic [63:0]             acc_q, acc_d;
    logic [5:0]              fill_q, fill_d;
    logic                    out_valid_d, flush_done_d, error_d;
    logic [WORD_WIDTH-1:0]   out_word_d;
    logic [31:0]             bit_count_d;
    logic [15:0]             word_count_d;

    logic                    len_ok;
    logic [6:0]              len_eff;
    logic [6:0]              total;
    logic [31:0]             code_mask;
    logic [63:0]             merged;

    // Accumulator is left-justified: valid bits occupy acc[63 -: fill], the rest stay zero
    always_comb begin
        len_ok    = in_enable && (in_length != 6'd0) &&
                    ({1'b0, in_length} <= 7'(MAX_CODE_LEN));
        len_eff   = len_ok ? {1'b0, in_length} : 7'd0;
        code_mask = 32'hFFFF_FFFF >> (7'd32 - len_eff);
        merged    = acc_q | ((({in_code & code_mask, 32'h0}) << (7'd32 - len_eff)) >> fill_q);
        total     = {1'b0, fill_q} + len_eff;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        out_valid_d  = 1'b0;
        flush_done_d = 1'b0;
        out_word_d   = out_word;
        bit_count_d  = bit_count;
        word_count_d = word_count;
        error_d      = error;

        if (clear) begin
            state_d      = RUN;
            acc_d        = '0;
            fill_d       = '0;
            bit_count_d  = '0;
            word_count_d = '0;
            error_d      = 1'b0;
        end else if (state_q == FLUSH2) begin
            // Remainder word is already zero-padded in the accumulator
            out_valid_d  = 1'b1;
            flush_done_d = 1'b1;
            out_word_d   = acc_q[63:32];
            word_count_d = word_count + 16'd1;
            acc_d        = '0;
            fill_d       = '0;
            state_d      = RUN;
            if (in_enable) begin
                error_d = 1'b1;
            end
        end else begin
            if (in_enable && ({1'b0, in_length} > 7'(MAX_CODE_LEN))) begin
                error_d = 1'b1;
            end
            bit_count_d = bit_count + {25'd0, len_eff};

            if (flush) begin
                if (total == 7'd0) begin
                    flush_done_d = 1'b1;
                end else if (total <= 7'd32) begin
                    out_valid_d  = 1'b1;
                    flush_done_d = 1'b1;
                    out_word_d   = merged[63:32];
                    word_count_d = word_count + 16'd1;
                    acc_d        = '0;
                    fill_d       = '0;
                end else begin
                    out_valid_d  = 1'b1;
                    out_word_d   = merged[63:32];
                    word_count_d = word_count + 16'd1;
                    acc_d        = {merged[31:0], 32'h0};
                    fill_d       = 6'(total - 7'd32);
                    state_d      = FLUSH2;
                end
            end else if (total >= 7'd32) begin
                out_valid_d  = 1'b1;
                out_word_d   = merged[63:32];
                word_count_d = word_count + 16'd1;
                acc_d        = {merged[31:0], 32'h0};
                fill_d       = 6'(total - 7'd32);
            end else begin
                acc_d  = merged;
                fill_d = total[5:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            acc_q      <= '0;
            fill_q     <= '0;
            out_valid  <= 1'b0;
            flush_done <= 1'b0;
            out_word   <= '0;
            bit_count  <= '0;
            word_count <= '0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            out_valid  <= out_valid_d;
            flush_done <= flush_done_d;
            out_word   <= out_word_d;
            bit_count  <= bit_count_d;
            word_count <= word_count_d;
            error      <= error_d;
        end
    end

    assign busy = (state_q == FLUSH2);

endmodule

// File: tb/tb_component_bit_packer.sv
// Self-checking bench for component_bit_packer: directed scenarios plus random
// traffic checked against a bit-queue reference model.
module tb_component_bit_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_enable = 1'b0;
    logic [31:0] in_code = '0;
    logic [5:0]  in_length = '0;
    logic        flush = 1'b0;
    logic        busy, out_valid, flush_done, error;
    logic [31:0] out_word, bit_count;
    logic [15:0] word_count;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    // Reference model: a plain FIFO of stream bits plus expected registered outputs
    bit          q[$];
    logic [31:0] m_bits;
    logic [15:0] m_words;
    logic        m_err, m_busy;
    logic        e_valid, e_done;
    logic [31:0] e_word;

    component_bit_packer #(.WORD_WIDTH(32), .MAX_CODE_LEN(32)) dut (
        .clock(clock), .reset(reset), .clear(clear), .in_enable(in_enable),
        .in_code(in_code), .in_length(in_length), .flush(flush), .busy(busy),
        .out_valid(out_valid), .out_word(out_word), .flush_done(flush_done),
        .bit_count(bit_count), .word_count(word_count), .error(error)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pop_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) begin
            if (q.size() > 0) begin
                w[31-i] = q.pop_front();
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_bits = '0; m_words = '0; m_err = 1'b0; m_busy = 1'b0;
        e_valid = 1'b0; e_done = 1'b0; e_word = '0;
    endtask

    // Drives one cycle of inputs, advances the model, then samples 1 time unit after the edge
    task automatic step(input logic en, input logic [31:0] code, input logic [5:0] len,
                        input logic fl, input logic clr);
        in_enable = en; in_code = code; in_length = len; flush = fl; clear = clr;
        e_valid = 1'b0; e_done = 1'b0;
        if (clr) begin
            q.delete();
            m_bits = '0; m_words = '0; m_err = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
            if (en) m_err = 1'b1;
            e_word = pop_word();
            e_valid = 1'b1; e_done = 1'b1;
            m_words = m_words + 16'd1;
            q.delete();
            m_busy = 1'b0;
        end else begin
            if (en && len > 6'd32) begin
                m_err = 1'b1;
            end else if (en && len != 6'd0) begin
                for (int i = int'(len) - 1; i >= 0; i--) q.push_back(code[i]);
                m_bits = m_bits + 32'(len);
            end
            if (fl) begin
                if (q.size() == 0) begin
                    e_done = 1'b1;
                end else begin
                    e_done = (q.size() <= 32);
                    m_busy = (q.size() > 32);
                    e_word = pop_word();
                    e_valid = 1'b1;
                    m_words = m_words + 16'd1;
                end
            end else if (q.size() >= 32) begin
                e_word = pop_word();
                e_valid = 1'b1;
                m_words = m_words + 16'd1;
            end
        end
        @(posedge clock);
        #1;
        in_enable = 1'b0; flush = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_cmp++;
        if ({out_valid, flush_done, busy, error} !== 4'b0 || out_word !== 32'h0 ||
            bit_count !== 32'h0 || word_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%b b=%b e=%b w=%h bc=%0d wc=%0d, want all 0",
                     out_valid, flush_done, busy, error, out_word, bit_count, word_count);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_pack_basic();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 32'hA, 6'd4, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early: out_valid=%b want 0", out_valid);
        end
        step(1'b1, 32'hA, 6'd4, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 32'hAAAA_AAAA || bit_count !== 32'd32 ||
            word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_word: v=%b w=%h bc=%0d wc=%0d want 1 aaaaaaaa 32 1",
                     out_valid, out_word, bit_count, word_count);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || out_word !== 32'hAAAA_AAAA) begin
            n_fail++; $display("FAIL basic_hold: v=%b w=%h want 0 aaaaaaaa", out_valid, out_word);
        end
    endtask

    task automatic test_flush_single();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h1, 6'd1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || flush_done !== 1'b1 || out_word !== 32'h8000_0000 ||
            bit_count !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_single: v=%b d=%b w=%h bc=%0d want 1 1 80000000 1",
                     out_valid, flush_done, out_word, bit_count);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || flush_done !== 1'b1 || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_empty: v=%b d=%b wc=%0d want 0 1 1", out_valid, flush_done, word_count);
        end
    endtask

    task automatic test_flush_two_words();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 32'hF, 6'd4, 1'b0, 1'b0);
        step(1'b1, 32'h3F, 6'd8, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 32'hFFFF_FFF3 || busy !== 1'b1 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush2_first: v=%b w=%h busy=%b d=%b want 1 fffffff3 1 0",
                     out_valid, out_word, busy, flush_done);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 32'hF000_0000 || flush_done !== 1'b1 ||
            word_count !== 16'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush2_rem: v=%b w=%h d=%b wc=%0d busy=%b want 1 f0000000 1 2 0",
                     out_valid, out_word, flush_done, word_count, busy);
        end
    endtask

    task automatic test_masking();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0005, 6'd2, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 6'd30, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 32'h7FFF_FFFF) begin
            n_fail++; $display("FAIL mask_low: v=%b w=%h want 1 7fffffff", out_valid, out_word);
        end
        step(1'b1, 32'hFFFF_FFFF, 6'd3, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 6'd29, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 6'd0, 1'b0, 1'b0);
        n_cmp++;
        if (out_word !== 32'hFFFF_FFFF || bit_count !== 32'd64 || word_count !== 16'd2 ||
            error !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_len0: w=%h bc=%0d wc=%0d err=%b want ffffffff 64 2 0",
                     out_word, bit_count, word_count, error);
        end
    endtask

    task automatic test_error();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 6'd33, 1'b0, 1'b0);
        n_cmp++;
        if (error !== 1'b1 || bit_count !== 32'd0) begin
            n_fail++; $display("FAIL err_len: err=%b bc=%0d want 1 0", error, bit_count);
        end
        step(1'b1, 32'h1, 6'd1, 1'b1, 1'b0);
        n_cmp++;
        if (error !== 1'b1 || out_word !== 32'h8000_0000 || flush_done !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b w=%h d=%b want 1 80000000 1", error, out_word, flush_done);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 32'hF, 6'd4, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 6'd32, 1'b1, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL err_pre_f2: busy=%b err=%b want 1 0", busy, error);
        end
        step(1'b1, 32'h5, 6'd3, 1'b0, 1'b0);
        n_cmp++;
        if (error !== 1'b1 || out_word !== 32'hF000_0000 || flush_done !== 1'b1 || bit_count !== 32'd36) begin
            n_fail++;
            $display("FAIL err_busy: err=%b w=%h d=%b bc=%0d want 1 f0000000 1 36",
                     error, out_word, flush_done, bit_count);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (error !== 1'b0 || bit_count !== 32'd0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b bc=%0d wc=%0d want 0 0 0", error, bit_count, word_count);
        end
    endtask

    task automatic test_reset_mid_word();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h9, 6'd4, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || bit_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b w=%h bc=%0d want 0 0 0", out_valid, out_word, bit_count);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        step(1'b1, 32'h1234_5678, 6'd32, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 32'h1234_5678 || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_clean: v=%b w=%h wc=%0d want 1 12345678 1", out_valid, out_word, word_count);
        end
    endtask

    task automatic test_clear_in_flush2();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 32'hF, 6'd4, 1'b0, 1'b0);
        step(1'b1, 32'h0, 6'd32, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || flush_done !== 1'b0 || busy !== 1'b0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_f2: v=%b d=%b busy=%b wc=%0d want 0 0 0 0",
                     out_valid, flush_done, busy, word_count);
        end
        step(1'b1, 32'hCAFE_BABE, 6'd32, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 32'hCAFE_BABE || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clear_clean: v=%b w=%h wc=%0d want 1 cafebabe 1", out_valid, out_word, word_count);
        end
    endtask

    task automatic test_random();
        logic        en, fl, clr;
        logic [5:0]  len;
        int unsigned r;
        step(1'b0, '0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            en  = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 99);
            len = (r < 3) ? 6'($urandom_range(33, 63)) :
                  (r < 8) ? 6'd0 : 6'($urandom_range(1, 32));
            fl  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 199) == 0);
            if (m_busy && $urandom_range(0, 9) != 0) en = 1'b0;
            step(en, $urandom, len, fl, clr);
            n_cmp++;
            if (out_valid !== e_valid || flush_done !== e_done || out_word !== e_word ||
                busy !== m_busy || bit_count !== m_bits || word_count !== m_words ||
                error !== m_err) begin
                n_fail++;
                $display("FAIL random[%0d]: v=%b d=%b w=%h b=%b bc=%0d wc=%0d e=%b want v=%b d=%b w=%h b=%b bc=%0d wc=%0d e=%b",
                         n, out_valid, flush_done, out_word, busy, bit_count, word_count, error,
                         e_valid, e_done, e_word, m_busy, m_bits, m_words, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pack_basic();
        test_flush_single();
        test_flush_two_words();
        test_masking();
        test_error();
        test_reset_mid_word();
        test_clear_in_flush2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
